// File: rtl/rr_arbiter.sv
// Four-way (N-way) round-robin request/grant arbiter with registered one-hot grants.
// Optional grant hold limit with forced release is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [2:0]   gnt_id,
    output logic         busy,
    output logic         timeout
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    generate
        if (N < 2 || N > 8 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
            $error("rr_arbiter: N must be 2..8 and MAX_HOLD 1..255");
        end
    endgenerate

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [2:0]      gnt_id_q, gnt_id_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            timeout_q, timeout_d;

    logic [N-1:0]    eff_req;
    logic            cur_req;
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   scan_idx;
    logic [PW-1:0]   next_ptr;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic [N-1:0]    blocked_q, blocked_d;

    // A requester cut off by the hold limit stays masked until it drops req.
    assign eff_req = req & ~blocked_q;
`else
    assign eff_req = req;
`endif

    // gnt_q is one-hot in GRANT, so this is req[gnt_id] without a variable index.
    assign cur_req = |(req & gnt_q);

    always_comb begin
        if (gnt_id_q == 3'(N - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = PW'(gnt_id_q + 3'd1);
        end
    end

    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = PW'((int'(ptr_q) + i) % N);
            if (!pick_valid && eff_req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        timeout_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        blocked_d  = blocked_q & req;
`endif

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = GRANT;
                    gnt_d      = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    gnt_id_d   = 3'(pick_idx);
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end

            GRANT: begin
                if (!cur_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt_q == 8'(MAX_HOLD - 1)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    ptr_d     = next_ptr;
                    timeout_d = 1'b1;
                    blocked_d = blocked_d | gnt_q;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
`endif
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= '0;
            timeout_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            blocked_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
            timeout_q  <= timeout_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            blocked_q  <= blocked_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = (state_q == GRANT);
    assign timeout = timeout_q;

endmodule
